// File: rtl/sensor_pkg.sv
// Shared defaults and event-FSM encoding for the sensor debouncer.
package sensor_pkg;

  localparam int N_SENSORS_DEF = 4;
  localparam int DB_CYCLES_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } evt_state_e;

  // Narrowest counter that can still hold DB_CYCLES-1.
  function automatic int cnt_width(input int db_cycles);
    return (db_cycles <= 2) ? 1 : $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: 2-flop synchronizer, persistence counter and debounced level.
module sensor_debounce_ch
  import sensor_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_toggle
);

  localparam int CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mismatch;
  logic             w_toggle;

  assign w_mismatch = r_sync2 ^ r_stable;
  // The edge that would push the count to DB_CYCLES flips the level instead.
  assign w_toggle   = w_mismatch && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_stable <= r_stable ^ w_toggle;
      if (!w_mismatch || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_toggle = w_toggle;

endmodule

// File: rtl/sensor_debouncer.sv
// Multi-channel sensor debouncer with a change-event handshake and sticky overrun.
//   state | meaning
//   IDLE  | no pending event, change_valid=0
//   PEND  | event pending, change_mask accumulates toggles until change_ready
module sensor_debouncer
  import sensor_pkg::*;
#(
  parameter int N_SENSORS = N_SENSORS_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] sensor_raw,
  output logic [N_SENSORS-1:0] sensor_stable,
  output logic                 change_valid,
  output logic [N_SENSORS-1:0] change_mask,
  input  logic                 change_ready,
  output logic                 overrun
);

  evt_state_e           r_state;
  evt_state_e           w_state_nxt;
  logic [N_SENSORS-1:0] r_mask;
  logic [N_SENSORS-1:0] w_mask_nxt;
  logic [N_SENSORS-1:0] w_toggle;
  logic                 r_overrun;
  logic                 w_overrun_nxt;
  logic                 w_any_toggle;

  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_ch
    sensor_debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (sensor_raw[gi]),
      .o_stable(sensor_stable[gi]),
      .o_toggle(w_toggle[gi])
    );
  end

  assign w_any_toggle = |w_toggle;

  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_overrun_nxt = r_overrun;
    case (r_state)
      ST_IDLE: begin
        if (w_any_toggle) begin
          w_state_nxt = ST_PEND;
          w_mask_nxt  = w_toggle;
        end
      end
      ST_PEND: begin
        if (!change_ready) begin
          w_mask_nxt    = r_mask | w_toggle;
          w_overrun_nxt = r_overrun | (|(r_mask & w_toggle));
        end else if (w_any_toggle) begin
          // Consumer takes the old event; same-edge toggles start the next one.
          w_mask_nxt = w_toggle;
        end else begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign change_valid = (r_state == ST_PEND);
  assign change_mask  = r_mask;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Directed and randomized checks of sensor_debouncer against a window-based reference model.
module tb_sensor_debouncer;

  localparam int NS = 4;
  localparam int DB = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] sensor_raw;
  logic [NS-1:0] sensor_stable;
  logic          change_valid;
  logic [NS-1:0] change_mask;
  logic          change_ready;
  logic          overrun;

  int n_checks;
  int n_fail;

  // Reference state: raw samples taken at past edges, hist[k] = raw sampled k edges ago.
  logic [NS-1:0] hist [1:DB+1];
  logic [NS-1:0] m_stable;
  logic [NS-1:0] m_mask;
  logic          m_valid;
  logic          m_overrun;

  sensor_debouncer #(
    .N_SENSORS(NS),
    .DB_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .sensor_stable(sensor_stable),
    .change_valid (change_valid),
    .change_mask  (change_mask),
    .change_ready (change_ready),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled on that edge.
  task automatic model_edge(input logic [NS-1:0] raw_v, input logic rdy_v, input logic rst_v);
    logic [NS-1:0] tog;
    if (rst_v) begin
      for (int k = 1; k <= DB + 1; k++) hist[k] = '0;
      m_stable  = '0;
      m_mask    = '0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end else begin
      // A level is accepted once the last DB synchronized samples all disagree with it.
      tog = '0;
      for (int i = 0; i < NS; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++) begin
          if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
        end
        tog[i] = all_diff;
      end
      for (int k = DB + 1; k >= 2; k--) hist[k] = hist[k-1];
      hist[1]  = raw_v;
      m_stable = m_stable ^ tog;
      if (!m_valid) begin
        if (tog != '0) begin
          m_valid = 1'b1;
          m_mask  = tog;
        end
      end else if (!rdy_v) begin
        if ((m_mask & tog) != '0) m_overrun = 1'b1;
        m_mask = m_mask | tog;
      end else if (tog != '0) begin
        m_mask = tog;
      end else begin
        m_valid = 1'b0;
        m_mask  = '0;
      end
    end
  endtask

  task automatic step(input logic [NS-1:0] raw_v, input logic rdy_v, input logic rst_v);
    @(negedge clk);
    sensor_raw   = raw_v;
    change_ready = rdy_v;
    rst          = rst_v;
    model_edge(raw_v, rdy_v, rst_v);
    @(posedge clk);
    #1;
    check_eq("stable", sensor_stable, m_stable);
    check_eq("valid", change_valid, m_valid);
    check_eq("mask", change_mask, m_mask);
    check_eq("overrun", overrun, m_overrun);
  endtask

  initial begin
    logic [NS-1:0] raw_r;
    logic          rdy_r;
    logic          rst_r;
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    sensor_raw   = '0;
    change_ready = 1'b0;
    for (int k = 1; k <= DB + 1; k++) hist[k] = '0;
    m_stable  = '0;
    m_mask    = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;

    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check_eq("reset_stable", sensor_stable, 4'b0000);
    check_eq("reset_valid", change_valid, 1'b0);

    // Single channel acceptance on edge 6, then handshake back to IDLE.
    for (int i = 1; i <= 6; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (i == 5) check_eq("lat_edge5_stable", sensor_stable, 4'b0000);
    end
    check_eq("lat_edge6_stable", sensor_stable, 4'b0001);
    check_eq("lat_edge6_valid", change_valid, 1'b1);
    check_eq("lat_edge6_mask", change_mask, 4'b0001);
    step(4'b0001, 1'b1, 1'b0);
    check_eq("ack_valid", change_valid, 1'b0);
    check_eq("ack_mask", change_mask, 4'b0000);

    // Short glitch on bit1 is rejected.
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      check_eq("glitch_stable", sensor_stable, 4'b0001);
      check_eq("glitch_valid", change_valid, 1'b0);
    end

    // Two channels accumulate into one pending event.
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0, 1'b0);
    check_eq("accum_valid", change_valid, 1'b1);
    check_eq("accum_mask", change_mask, 4'b0101);
    check_eq("accum_overrun", overrun, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    check_eq("accum_ack_valid", change_valid, 1'b0);

    // New toggle on the accept edge starts a fresh event.
    for (int i = 0; i < 6; i++) step(4'b0101, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) step(4'b1101, (i == 6), 1'b0);
    check_eq("handover_valid", change_valid, 1'b1);
    check_eq("handover_mask", change_mask, 4'b1000);
    step(4'b1101, 1'b1, 1'b0);

    // Same channel changes twice while pending -> sticky overrun.
    for (int i = 0; i < 8; i++) step(4'b1100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b1101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(4'b1100, 1'b0, 1'b0);
    check_eq("ovr_mask", change_mask, 4'b0001);
    check_eq("ovr_flag", overrun, 1'b1);
    check_eq("ovr_stable", sensor_stable, 4'b1100);
    for (int i = 0; i < 3; i++) step(4'b1100, 1'b1, 1'b0);
    check_eq("ovr_sticky", overrun, 1'b1);

    // Reset mid-debounce discards partial counts.
    for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    check_eq("rst_stable", sensor_stable, 4'b0000);
    check_eq("rst_valid", change_valid, 1'b0);
    check_eq("rst_mask", change_mask, 4'b0000);
    check_eq("rst_overrun", overrun, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      if (i == 5) check_eq("rst_edge5_stable", sensor_stable, 4'b0000);
    end
    check_eq("rst_edge6_stable", sensor_stable, 4'b0100);

    // Random phase: sparse bit flips give both glitches and held changes.
    raw_r = 4'b0100;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 9) == 0) raw_r[i] = ~raw_r[i];
      end
      rdy_r = ($urandom_range(0, 3) == 0);
      rst_r = ($urandom_range(0, 499) == 0);
      step(raw_r, rdy_r, rst_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_debouncer.md
SENSOR_DEBOUNCER -- requirements
Module: sensor_debouncer

Interface
REQ-001 Parameter N_SENSORS, default 4: number of sensor channels.
REQ-002 Parameter DB_CYCLES, default 16: consecutive synchronized cycles a changed level must persist before acceptance; legal range 2..255.
REQ-003 Port clk, input, 1: single clock, rising-edge active.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port sensor_raw, input, N_SENSORS: asynchronous raw sensor lines.
REQ-006 Port sensor_stable, output, N_SENSORS: debounced levels, drive the sensor_inputs bus of the home automation controller.
REQ-007 Port change_valid, output, 1: pending change event.
REQ-008 Port change_mask, output, N_SENSORS: channels that changed since the last accepted event; meaningful only while change_valid=1.
REQ-009 Port change_ready, input, 1: consumer accepts the event.
REQ-010 Port overrun, output, 1: sticky flag, a channel changed again while its change was still pending.

Function
REQ-011 Each sensor_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per channel: synchronized bit equal to sensor_stable bit SHALL clear its counter to 0; unequal SHALL increment it.
REQ-013 When a channel's counter equals DB_CYCLES-1 and the mismatch persists at the edge, the stable bit SHALL toggle on that edge and the counter SHALL clear.
REQ-014 Latency: with the edge that first samples a held raw change counted as edge 1, sensor_stable SHALL change on edge DB_CYCLES+2.
REQ-015 A mismatch lasting fewer than DB_CYCLES synchronized cycles SHALL clear the counter and leave sensor_stable unchanged.
REQ-016 Event FSM states: IDLE (change_valid=0), PEND (change_valid=1).
REQ-017 IDLE: on an edge where any stable bit toggles, change_mask SHALL load the toggle vector and state SHALL go to PEND (valid asserts on the same edge sensor_stable updates).
REQ-018 PEND, change_ready=0: new toggles SHALL be OR-ed into change_mask; valid stays 1.
REQ-019 PEND, change_ready=1, no new toggles: state SHALL return to IDLE and change_mask SHALL clear to 0.
REQ-020 PEND, change_ready=1 with new toggles on the same edge: change_mask SHALL load only the new toggles and state SHALL remain PEND.
REQ-021 A toggle on a channel whose mask bit is already 1 while in PEND with change_ready=0 SHALL set overrun; overrun clears only on reset.
REQ-022 Multiple channels toggling on one edge SHALL be reported in one event.
REQ-023 change_ready while IDLE SHALL have no effect.

Reset
REQ-024 rst=1 at an edge SHALL clear synchronizers, counters, sensor_stable, change_mask, change_valid and overrun to 0 and set state IDLE.
REQ-025 Reset mid-debounce SHALL discard partial counts; debouncing restarts from reset values after release.

Structure
REQ-026 Shared package sensor_pkg SHALL hold N_SENSORS and DB_CYCLES defaults and the IDLE/PEND state encoding.
REQ-027 Counter width SHALL be a local constant derived from DB_CYCLES.
REQ-028 Per-channel synchronizer+counter+stable bit SHALL be sub-module sensor_debounce_ch, instantiated N_SENSORS times via generate; event FSM stays in the top.

Verification (DB_CYCLES=4)
REQ-029 raw 0000->0001 held, ready=0 -> sensor_stable=0001 and change_valid=1, change_mask=0001 on edge 6; ready=1 next edge -> valid 0, mask 0000.
REQ-030 raw bit1 high for 3 cycles then low -> sensor_stable and change_valid stay 0 throughout.
REQ-031 ready=0; bit0 toggles, bit2 toggles 10 cycles later -> valid held 1, mask 0101, overrun 0; ready=1 -> IDLE.
REQ-032 bit0 pending; bit3 toggle on same edge as ready=1 -> valid stays 1, mask=1000.
REQ-033 ready=0; bit0 goes 1 then back 0 (each held 10 cycles) -> mask 0001, overrun=1, sensor_stable bit0 ends 0.
REQ-034 raw 0100 held 3 cycles, rst pulsed 1 cycle -> all outputs 0; raw still 0100 -> sensor_stable=0100 on edge 6 after release.
